// File: rtl/squelch_ctrl.sv
// RSSI squelch controller: windowed RSSI averaging with open/close hysteresis
// and debounce counters, gating the PWM audio stage.
//
// state   | meaning
// MUTED   | audio gated, waiting for a window average at/above thr_open
// ATTACK  | counting consecutive strong windows toward OPEN_CNT
// OPEN    | audio on, watching for a window average below thr_close
// RELEASE | audio on, counting consecutive weak windows toward CLOSE_CNT
module squelch_ctrl #(
  parameter int RSSI_WIDTH = 26,
  parameter int AVG_LOG2   = 2,
  parameter int OPEN_CNT   = 3,
  parameter int CLOSE_CNT  = 4
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  sample_valid,
  input  logic [RSSI_WIDTH-1:0] rssi_in,
  input  logic                  sq_enable,
  input  logic [RSSI_WIDTH-1:0] thr_open,
  input  logic [RSSI_WIDTH-1:0] thr_close,
  output logic                  pwm_enable,
  output logic [1:0]            sq_state,
  output logic [RSSI_WIDTH-1:0] rssi_avg,
  output logic                  avg_valid,
  output logic                  open_evt
);

  localparam int SUM_W  = RSSI_WIDTH + AVG_LOG2;
  localparam int SCNT_W = AVG_LOG2 + 1;
  localparam logic [SCNT_W-1:0] LAST_SAMPLE = SCNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [3:0] OPEN_TC  = 4'(OPEN_CNT);
  localparam logic [3:0] CLOSE_TC = 4'(CLOSE_CNT);

  typedef enum logic [1:0] {
    MUTED   = 2'd0,
    ATTACK  = 2'd1,
    OPEN    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  logic [SUM_W-1:0]      sum_q, sum_d, sum_acc;
  logic [SCNT_W-1:0]     scnt_q, scnt_d;
  logic [RSSI_WIDTH-1:0] rssi_avg_q, rssi_avg_d;
  logic                  avg_valid_q, avg_valid_d;
  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d, cnt_inc;
  logic                  pwm_q, pwm_d;
  logic                  evt_q, evt_d;
  logic                  above_open, below_close;

  // The window closes on the edge capturing its last sample, so a strobe in
  // the avg_valid cycle already lands in a cleared accumulator.
  always_comb begin
    sum_acc     = sum_q + SUM_W'(rssi_in);
    sum_d       = sum_q;
    scnt_d      = scnt_q;
    rssi_avg_d  = rssi_avg_q;
    avg_valid_d = 1'b0;
    if (sample_valid) begin
      if (scnt_q == LAST_SAMPLE) begin
        sum_d       = '0;
        scnt_d      = '0;
        rssi_avg_d  = sum_acc[SUM_W-1:AVG_LOG2];
        avg_valid_d = 1'b1;
      end else begin
        sum_d  = sum_acc;
        scnt_d = scnt_q + SCNT_W'(1);
      end
    end
  end

  always_comb begin
    above_open  = (rssi_avg_q >= thr_open);
    below_close = (rssi_avg_q < thr_close);
    cnt_inc     = cnt_q + 4'd1;
    state_d     = state_q;
    cnt_d       = cnt_q;
    evt_d       = 1'b0;
    if (!sq_enable) begin
      state_d = MUTED;
      cnt_d   = '0;
    end else if (avg_valid_q) begin
      case (state_q)
        MUTED: begin
          if (above_open) begin
            state_d = ATTACK;
            cnt_d   = 4'd1;
          end
        end
        ATTACK: begin
          if (above_open) begin
            if (cnt_inc == OPEN_TC) begin
              state_d = OPEN;
              cnt_d   = '0;
              evt_d   = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = MUTED;
            cnt_d   = '0;
          end
        end
        OPEN: begin
          if (below_close) begin
            state_d = RELEASE;
            cnt_d   = 4'd1;
          end
        end
        RELEASE: begin
          if (below_close) begin
            if (cnt_inc == CLOSE_TC) begin
              state_d = MUTED;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = OPEN;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = MUTED;
          cnt_d   = '0;
        end
      endcase
    end
    pwm_d = !sq_enable || (state_d == OPEN) || (state_d == RELEASE);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sum_q       <= '0;
      scnt_q      <= '0;
      rssi_avg_q  <= '0;
      avg_valid_q <= 1'b0;
      state_q     <= MUTED;
      cnt_q       <= '0;
      pwm_q       <= 1'b0;
      evt_q       <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      scnt_q      <= scnt_d;
      rssi_avg_q  <= rssi_avg_d;
      avg_valid_q <= avg_valid_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pwm_q       <= pwm_d;
      evt_q       <= evt_d;
    end
  end

  assign pwm_enable = pwm_q;
  assign sq_state   = state_q;
  assign rssi_avg   = rssi_avg_q;
  assign avg_valid  = avg_valid_q;
  assign open_evt   = evt_q;

endmodule

// File: tb/tb_squelch_ctrl.sv
// Directed bench for squelch_ctrl: window-level vector table plus hand-written
// sequences for truncation, back-to-back strobes, bypass and reset.
module tb_squelch_ctrl;

  localparam int W = 26;

  logic         clk_in = 1'b0;
  logic         rst;
  logic         sample_valid;
  logic [W-1:0] rssi_in;
  logic         sq_enable;
  logic [W-1:0] thr_open;
  logic [W-1:0] thr_close;
  logic         pwm_enable;
  logic [1:0]   sq_state;
  logic [W-1:0] rssi_avg;
  logic         avg_valid;
  logic         open_evt;

  int n_total = 0;
  int n_pass  = 0;

  squelch_ctrl dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .sample_valid (sample_valid),
    .rssi_in      (rssi_in),
    .sq_enable    (sq_enable),
    .thr_open     (thr_open),
    .thr_close    (thr_close),
    .pwm_enable   (pwm_enable),
    .sq_state     (sq_state),
    .rssi_avg     (rssi_avg),
    .avg_valid    (avg_valid),
    .open_evt     (open_evt)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        en;
    int unsigned val;
    int unsigned avg;
    logic [1:0]  st;
    logic        pwm;
    logic        evt;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic strobe(input int unsigned v);
    sample_valid = 1'b1;
    rssi_in      = W'(v);
    @(posedge clk_in);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic window(input int unsigned v);
    repeat (4) strobe(v);
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pwm"}, 32'(pwm_enable), 0);
    chk({tag, "_state"}, 32'(sq_state), 0);
    chk({tag, "_avg"}, 32'(rssi_avg), 0);
    chk({tag, "_avg_valid"}, 32'(avg_valid), 0);
    chk({tag, "_open_evt"}, 32'(open_evt), 0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1000, 1000, 2'd1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1000, 1000, 2'd1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1000, 1000, 2'd2, 1'b1, 1'b1};
    vecs[3]  = '{1'b1,  400,  400, 2'd3, 1'b1, 1'b0};
    vecs[4]  = '{1'b1,  400,  400, 2'd3, 1'b1, 1'b0};
    vecs[5]  = '{1'b1,  400,  400, 2'd3, 1'b1, 1'b0};
    vecs[6]  = '{1'b1,  600,  600, 2'd2, 1'b1, 1'b0};
    vecs[7]  = '{1'b1,  400,  400, 2'd3, 1'b1, 1'b0};
    vecs[8]  = '{1'b1,  400,  400, 2'd3, 1'b1, 1'b0};
    vecs[9]  = '{1'b1,  400,  400, 2'd3, 1'b1, 1'b0};
    vecs[10] = '{1'b1,  400,  400, 2'd0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1000, 1000, 2'd1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1000, 1000, 2'd1, 1'b0, 1'b0};
    vecs[13] = '{1'b1,  700,  700, 2'd0, 1'b0, 1'b0};
    vecs[14] = '{1'b1,  800,  800, 2'd1, 1'b0, 1'b0};
    vecs[15] = '{1'b1,  800,  800, 2'd1, 1'b0, 1'b0};
    vecs[16] = '{1'b1,  800,  800, 2'd2, 1'b1, 1'b1};
    vecs[17] = '{1'b1,  500,  500, 2'd2, 1'b1, 1'b0};
    vecs[18] = '{1'b1,  499,  499, 2'd3, 1'b1, 1'b0};
    vecs[19] = '{1'b1,  500,  500, 2'd2, 1'b1, 1'b0};
    vecs[20] = '{1'b1,  499,  499, 2'd3, 1'b1, 1'b0};
    vecs[21] = '{1'b1,  499,  499, 2'd3, 1'b1, 1'b0};
    vecs[22] = '{1'b1,  499,  499, 2'd3, 1'b1, 1'b0};
    vecs[23] = '{1'b1,  499,  499, 2'd0, 1'b0, 1'b0};
    vecs[24] = '{1'b1, 1000, 1000, 2'd1, 1'b0, 1'b0};

    rst          = 1'b1;
    sample_valid = 1'b0;
    rssi_in      = '0;
    sq_enable    = 1'b1;
    thr_open     = W'(800);
    thr_close    = W'(500);
    repeat (2) @(posedge clk_in);
    #1;
    chk_reset_outputs("por");
    rst = 1'b0;
    step();

    // truncating average and value hold between windows
    strobe(1); strobe(2); strobe(3);
    chk("trunc_no_early_valid", 32'(avg_valid), 0);
    strobe(3);
    chk("trunc_avg_valid", 32'(avg_valid), 1);
    chk("trunc_avg", 32'(rssi_avg), 2);
    step();
    chk("trunc_valid_one_cycle", 32'(avg_valid), 0);
    chk("trunc_avg_hold", 32'(rssi_avg), 2);
    chk("trunc_state", 32'(sq_state), 0);

    // held strobe counts every cycle; strobe in avg_valid cycle opens next window
    sample_valid = 1'b1;
    rssi_in      = W'(100);
    repeat (4) @(posedge clk_in);
    #1;
    chk("b2b_avg1", 32'(rssi_avg), 100);
    chk("b2b_valid1", 32'(avg_valid), 1);
    rssi_in = W'(200);
    repeat (4) @(posedge clk_in);
    #1;
    sample_valid = 1'b0;
    chk("b2b_avg2", 32'(rssi_avg), 200);
    chk("b2b_valid2", 32'(avg_valid), 1);
    step();
    chk("b2b_state", 32'(sq_state), 0);

    for (int i = 0; i < NV; i++) begin
      sq_enable = vecs[i].en;
      window(vecs[i].val);
      chk($sformatf("v%0d_avg_valid", i), 32'(avg_valid), 1);
      chk($sformatf("v%0d_avg", i), 32'(rssi_avg), vecs[i].avg);
      step();
      chk($sformatf("v%0d_state", i), 32'(sq_state), 32'(vecs[i].st));
      chk($sformatf("v%0d_pwm", i), 32'(pwm_enable), 32'(vecs[i].pwm));
      chk($sformatf("v%0d_open_evt", i), 32'(open_evt), 32'(vecs[i].evt));
      if (vecs[i].evt) begin
        step();
        chk($sformatf("v%0d_evt_one_cycle", i), 32'(open_evt), 0);
      end
    end

    // bypass from ATTACK, averaging continues, then re-enable
    sq_enable = 1'b0;
    step();
    chk("byp_pwm", 32'(pwm_enable), 1);
    chk("byp_state", 32'(sq_state), 0);
    window(1000);
    chk("byp_avg", 32'(rssi_avg), 1000);
    chk("byp_avg_valid", 32'(avg_valid), 1);
    step();
    chk("byp_state_held", 32'(sq_state), 0);
    chk("byp_pwm_held", 32'(pwm_enable), 1);
    chk("byp_no_evt", 32'(open_evt), 0);
    sq_enable = 1'b1;
    strobe(100);
    chk("reen_pwm_drop", 32'(pwm_enable), 0);
    strobe(100); strobe(100); strobe(100);
    chk("reen_avg", 32'(rssi_avg), 100);
    step();
    chk("reen_state", 32'(sq_state), 0);
    chk("reen_pwm", 32'(pwm_enable), 0);

    // reset mid-ATTACK and mid-window
    window(1000);
    step();
    chk("prerst_state", 32'(sq_state), 1);
    strobe(3000); strobe(3000);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst_async");
    step();
    chk_reset_outputs("rst_held");
    rst = 1'b0;
    step();
    strobe(50); strobe(50); strobe(50);
    chk("postrst_no_early_valid", 32'(avg_valid), 0);
    strobe(50);
    chk("postrst_avg", 32'(rssi_avg), 50);
    chk("postrst_avg_valid", 32'(avg_valid), 1);
    step();
    chk("postrst_state", 32'(sq_state), 0);
    window(1000);
    step();
    chk("postrst_attack", 32'(sq_state), 1);
    chk("postrst_pwm", 32'(pwm_enable), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
